// File: rtl/ls_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsb_defs (package)
// Description : Shared constants for the load/store buffer: the free-tag
//               marker, the opcode encodings and a store-class helper.
//               Constants are plain ints so users can size them to their own
//               TAG_W / OP_W parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package lsb_defs;

    // Tag value meaning "operand value is present"
    localparam int TAG_FREE = 0;

    // Opcode encodings
    localparam int NOP = 0;
    localparam int LB  = 1;
    localparam int LH  = 2;
    localparam int LW  = 3;
    localparam int LBU = 4;
    localparam int LHU = 5;
    localparam int SB  = 6;
    localparam int SH  = 7;
    localparam int SW  = 8;

    function automatic logic is_store(input int op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ls_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : ls_buffer_if
// Description : Bundles the dispatcher insert port, the two result
//               broadcasts and the LS issue port of the load/store buffer.
//               slave  : the buffer side
//               master : dispatcher / broadcast / LS unit side
// Revision    : 1.0 - initial release
// ============================================================================
interface ls_buffer_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    // Dispatcher insert
    logic              inEn;
    logic [OP_W-1:0]   inOp;
    logic [DATA_W-1:0] inOperandO;
    logic [DATA_W-1:0] inOperandT;
    logic [TAG_W-1:0]  inTagO;
    logic [TAG_W-1:0]  inTagT;
    logic [DATA_W-1:0] inImm;
    logic [TAG_W-1:0]  inWrtTag;
    logic              lsbFull;
    // Result broadcasts
    logic              ALUen;
    logic [TAG_W-1:0]  ALUtag;
    logic [DATA_W-1:0] ALUdata;
    logic              LSROBen;
    logic [TAG_W-1:0]  LSROBtag;
    logic [DATA_W-1:0] LSROBdata;
    // Issue to LS unit
    logic              LSunwork;
    logic              LSworkEn;
    logic [DATA_W-1:0] operandO;
    logic [DATA_W-1:0] operandT;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  wrtTag;
    logic [OP_W-1:0]   opCode;

    modport slave (
        input  inEn, inOp, inOperandO, inOperandT, inTagO, inTagT, inImm, inWrtTag,
        input  ALUen, ALUtag, ALUdata, LSROBen, LSROBtag, LSROBdata, LSunwork,
        output lsbFull, LSworkEn, operandO, operandT, imm, wrtTag, opCode
    );

    modport master (
        output inEn, inOp, inOperandO, inOperandT, inTagO, inTagT, inImm, inWrtTag,
        output ALUen, ALUtag, ALUdata, LSROBen, LSROBtag, LSROBdata, LSunwork,
        input  lsbFull, LSworkEn, operandO, operandT, imm, wrtTag, opCode
    );
endinterface
`default_nettype wire

// File: rtl/ls_buffer_cdb_snoop.sv
`default_nettype none
// ============================================================================
// Module      : cdb_snoop
// Description : Resolves one source operand against the ALU and LS result
//               broadcasts. A pending tag matching an enabled broadcast is
//               replaced by TAG_FREE and its data captured; ALU has priority.
// Ports       : tag/data           - current operand state
//               alu_* / ls_*       - broadcast enable, tag, data
//               tag_nx / data_nx   - operand state after this cycle's snoop
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_snoop
    import lsb_defs::*;
#(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  wire logic [TAG_W-1:0]  tag,
    input  wire logic [DATA_W-1:0] data,
    input  wire logic              alu_en,
    input  wire logic [TAG_W-1:0]  alu_tag,
    input  wire logic [DATA_W-1:0] alu_data,
    input  wire logic              ls_en,
    input  wire logic [TAG_W-1:0]  ls_tag,
    input  wire logic [DATA_W-1:0] ls_data,
    output logic      [TAG_W-1:0]  tag_nx,
    output logic      [DATA_W-1:0] data_nx
);
    localparam logic [TAG_W-1:0] C_TAG_FREE = TAG_W'(TAG_FREE);

    always_comb begin
        tag_nx  = tag;
        data_nx = data;
        if (tag != C_TAG_FREE) begin
            if (alu_en && (alu_tag == tag)) begin
                tag_nx  = C_TAG_FREE;
                data_nx = alu_data;
            end else if (ls_en && (ls_tag == tag)) begin
                tag_nx  = C_TAG_FREE;
                data_nx = ls_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ls_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ls_buffer
// Description : In-order load/store queue. Circular FIFO of LSB_SIZE
//               entries; every stored operand snoops both result broadcasts,
//               and the head entry issues to the LS unit once its operands
//               are present and LS can accept work.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - ls_buffer_if.slave (insert, broadcasts, issue)
// Revision    : 1.0 - initial release
// ============================================================================
module ls_buffer
    import lsb_defs::*;
#(
    parameter int LSB_SIZE = 8,     // power of two, >= 2
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32,
    parameter int OP_W     = 6
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ls_buffer_if.slave bus
);
    localparam int               IDX_W      = $clog2(LSB_SIZE);
    localparam logic [TAG_W-1:0] C_TAG_FREE = TAG_W'(TAG_FREE);

    // Queue pointers
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    // Per-entry state, exposed from the generate block for the head mux
    logic              w_valid  [LSB_SIZE];
    logic [OP_W-1:0]   w_op     [LSB_SIZE];
    logic [DATA_W-1:0] w_imm    [LSB_SIZE];
    logic [TAG_W-1:0]  w_wrt_tag[LSB_SIZE];
    logic [TAG_W-1:0]  w_tag_o  [LSB_SIZE];
    logic [DATA_W-1:0] w_data_o [LSB_SIZE];
    logic [TAG_W-1:0]  w_tag_t  [LSB_SIZE];
    logic [DATA_W-1:0] w_data_t [LSB_SIZE];

    // Issue registers
    logic              r_work_en;
    logic [DATA_W-1:0] r_operand_o;
    logic [DATA_W-1:0] r_operand_t;
    logic [DATA_W-1:0] r_imm_out;
    logic [TAG_W-1:0]  r_wrt_tag_out;
    logic [OP_W-1:0]   r_op_code;

    logic              w_full;
    logic              w_insert;
    logic              w_issue;
    logic              w_head_store;
    logic              w_head_ready;
    logic [TAG_W-1:0]  w_ins_tag_o;
    logic [DATA_W-1:0] w_ins_data_o;
    logic [TAG_W-1:0]  w_ins_tag_t;
    logic [DATA_W-1:0] w_ins_data_t;

    assign w_full   = (r_count == (IDX_W+1)'(LSB_SIZE));
    // A full buffer drops the insert even if the head pops at the same edge
    assign w_insert = bus.inEn && !w_full;

    // Readiness looks only at registered entry state: a broadcast resolving
    // the head becomes visible one edge later.
    assign w_head_store = is_store(int'(w_op[r_head]));
    assign w_head_ready = w_valid[r_head] && (w_tag_o[r_head] == C_TAG_FREE) &&
                          (!w_head_store || (w_tag_t[r_head] == C_TAG_FREE));
    assign w_issue      = !r_work_en && bus.LSunwork && w_head_ready;

    // Incoming operands are snooped so a producer broadcasting in the insert
    // cycle is captured.
    cdb_snoop #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_ins_snoop_o (
        .tag(bus.inTagO), .data(bus.inOperandO),
        .alu_en(bus.ALUen), .alu_tag(bus.ALUtag), .alu_data(bus.ALUdata),
        .ls_en(bus.LSROBen), .ls_tag(bus.LSROBtag), .ls_data(bus.LSROBdata),
        .tag_nx(w_ins_tag_o), .data_nx(w_ins_data_o)
    );

    cdb_snoop #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_ins_snoop_t (
        .tag(bus.inTagT), .data(bus.inOperandT),
        .alu_en(bus.ALUen), .alu_tag(bus.ALUtag), .alu_data(bus.ALUdata),
        .ls_en(bus.LSROBen), .ls_tag(bus.LSROBtag), .ls_data(bus.LSROBdata),
        .tag_nx(w_ins_tag_t), .data_nx(w_ins_data_t)
    );

    for (genvar i = 0; i < LSB_SIZE; i++) begin : g_entry
        logic              r_valid;
        logic [OP_W-1:0]   r_op;
        logic [DATA_W-1:0] r_imm;
        logic [TAG_W-1:0]  r_wrt_tag;
        logic [TAG_W-1:0]  r_tag_o;
        logic [DATA_W-1:0] r_data_o;
        logic [TAG_W-1:0]  r_tag_t;
        logic [DATA_W-1:0] r_data_t;
        logic [TAG_W-1:0]  w_tag_o_nx;
        logic [DATA_W-1:0] w_data_o_nx;
        logic [TAG_W-1:0]  w_tag_t_nx;
        logic [DATA_W-1:0] w_data_t_nx;
        logic              w_write;
        logic              w_pop;

        assign w_write = w_insert && (r_tail == IDX_W'(i));
        assign w_pop   = w_issue  && (r_head == IDX_W'(i));

        cdb_snoop #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_snoop_o (
            .tag(r_tag_o), .data(r_data_o),
            .alu_en(bus.ALUen), .alu_tag(bus.ALUtag), .alu_data(bus.ALUdata),
            .ls_en(bus.LSROBen), .ls_tag(bus.LSROBtag), .ls_data(bus.LSROBdata),
            .tag_nx(w_tag_o_nx), .data_nx(w_data_o_nx)
        );

        cdb_snoop #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_snoop_t (
            .tag(r_tag_t), .data(r_data_t),
            .alu_en(bus.ALUen), .alu_tag(bus.ALUtag), .alu_data(bus.ALUdata),
            .ls_en(bus.LSROBen), .ls_tag(bus.LSROBtag), .ls_data(bus.LSROBdata),
            .tag_nx(w_tag_t_nx), .data_nx(w_data_t_nx)
        );

        // Insert goes to tail, pop comes from head; they cannot hit the same
        // slot because an empty head is never ready and a full tail is never
        // written.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid   <= 1'b0;
                r_op      <= OP_W'(NOP);
                r_imm     <= '0;
                r_wrt_tag <= C_TAG_FREE;
                r_tag_o   <= C_TAG_FREE;
                r_data_o  <= '0;
                r_tag_t   <= C_TAG_FREE;
                r_data_t  <= '0;
            end else if (w_write) begin
                r_valid   <= 1'b1;
                r_op      <= bus.inOp;
                r_imm     <= bus.inImm;
                r_wrt_tag <= bus.inWrtTag;
                r_tag_o   <= w_ins_tag_o;
                r_data_o  <= w_ins_data_o;
                r_tag_t   <= w_ins_tag_t;
                r_data_t  <= w_ins_data_t;
            end else begin
                if (w_pop) begin
                    r_valid <= 1'b0;
                end
                r_tag_o  <= w_tag_o_nx;
                r_data_o <= w_data_o_nx;
                r_tag_t  <= w_tag_t_nx;
                r_data_t <= w_data_t_nx;
            end
        end

        assign w_valid[i]   = r_valid;
        assign w_op[i]      = r_op;
        assign w_imm[i]     = r_imm;
        assign w_wrt_tag[i] = r_wrt_tag;
        assign w_tag_o[i]   = r_tag_o;
        assign w_data_o[i]  = r_data_o;
        assign w_tag_t[i]   = r_tag_t;
        assign w_data_t[i]  = r_data_t;
    end

    // Pointers wrap naturally since LSB_SIZE is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_insert) begin
                r_tail <= r_tail + IDX_W'(1);
            end
            if (w_issue) begin
                r_head <= r_head + IDX_W'(1);
            end
            case ({w_insert, w_issue})
                2'b10:   r_count <= r_count + (IDX_W+1)'(1);
                2'b01:   r_count <= r_count - (IDX_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle issue strobe; payload holds between issues
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work_en     <= 1'b0;
            r_operand_o   <= '0;
            r_operand_t   <= '0;
            r_imm_out     <= '0;
            r_wrt_tag_out <= C_TAG_FREE;
            r_op_code     <= OP_W'(NOP);
        end else begin
            r_work_en <= w_issue;
            if (w_issue) begin
                r_operand_o   <= w_data_o[r_head];
                r_operand_t   <= w_head_store ? w_data_t[r_head] : '0;
                r_imm_out     <= w_imm[r_head];
                r_wrt_tag_out <= w_wrt_tag[r_head];
                r_op_code     <= w_op[r_head];
            end
        end
    end

    assign bus.lsbFull  = w_full;
    assign bus.LSworkEn = r_work_en;
    assign bus.operandO = r_operand_o;
    assign bus.operandT = r_operand_t;
    assign bus.imm      = r_imm_out;
    assign bus.wrtTag   = r_wrt_tag_out;
    assign bus.opCode   = r_op_code;
endmodule
`default_nettype wire

// File: tb/tb_ls_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ls_buffer
// Description : Scoreboard bench for ls_buffer. Stimulus pushes the expected
//               issue (payload plus the cycle it must appear in); a monitor
//               on the falling edge pops and compares every LSworkEn strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_buffer;
    import lsb_defs::*;

    localparam logic [3:0] C_FREE = 4'(TAG_FREE);

    typedef struct {
        logic [31:0] opo;
        logic [31:0] opt;
        logic [31:0] imm;
        logic [3:0]  wtag;
        logic [5:0]  op;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    ls_buffer_if #(.TAG_W(4), .DATA_W(32), .OP_W(6)) bus ();

    ls_buffer #(.LSB_SIZE(8), .TAG_W(4), .DATA_W(32), .OP_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every issue strobe must match the next scoreboard entry
    always @(negedge clk) begin
        if (bus.LSworkEn !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue cyc=%0d op=%0d opO=%h", cyc, bus.opCode, bus.operandO);
            end else begin
                e = sb.pop_front();
                if (bus.operandO !== e.opo || bus.operandT !== e.opt || bus.imm !== e.imm ||
                    bus.wrtTag !== e.wtag || bus.opCode !== e.op || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL issue got cyc=%0d op=%0d opO=%h opT=%h imm=%h wtag=%0d expected cyc=%0d op=%0d opO=%h opT=%h imm=%h wtag=%0d",
                             cyc, bus.opCode, bus.operandO, bus.operandT, bus.imm, bus.wrtTag,
                             e.cyc, e.op, e.opo, e.opt, e.imm, e.wtag);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] opo, input logic [31:0] opt, input logic [31:0] imm,
                        input logic [3:0] wtag, input int op, input int at);
        exp_t x;
        x.opo = opo; x.opt = opt; x.imm = imm; x.wtag = wtag; x.op = 6'(op); x.cyc = at;
        sb.push_back(x);
    endtask

    task automatic ins(input int op, input logic [31:0] oo, input logic [3:0] to,
                       input logic [31:0] ot, input logic [3:0] tt,
                       input logic [31:0] im, input logic [3:0] wt);
        bus.inOp       = 6'(op);
        bus.inOperandO = oo;
        bus.inTagO     = to;
        bus.inOperandT = ot;
        bus.inTagT     = tt;
        bus.inImm      = im;
        bus.inWrtTag   = wt;
        bus.inEn       = 1'b1;
        wait_cyc(1);
        bus.inEn       = 1'b0;
    endtask

    task automatic bcast_alu(input logic [3:0] tag, input logic [31:0] data);
        bus.ALUen   = 1'b1;
        bus.ALUtag  = tag;
        bus.ALUdata = data;
        wait_cyc(1);
        bus.ALUen   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int s;
        bus.inEn = 1'b0; bus.inOp = '0; bus.inOperandO = '0; bus.inOperandT = '0;
        bus.inTagO = C_FREE; bus.inTagT = C_FREE; bus.inImm = '0; bus.inWrtTag = C_FREE;
        bus.ALUen = 1'b0; bus.ALUtag = '0; bus.ALUdata = '0;
        bus.LSROBen = 1'b0; bus.LSROBtag = '0; bus.LSROBdata = '0;
        bus.LSunwork = 1'b0;

        wait_cyc(3);
        rst = 1'b0;

        // Reset state
        chk("rst_workEn",  32'(bus.LSworkEn), 32'd0);
        chk("rst_full",    32'(bus.lsbFull),  32'd0);
        chk("rst_operandO", bus.operandO, 32'd0);
        chk("rst_operandT", bus.operandT, 32'd0);
        chk("rst_imm",      bus.imm,      32'd0);
        chk("rst_wrtTag",  32'(bus.wrtTag), 32'(C_FREE));
        chk("rst_opCode",  32'(bus.opCode), 32'(NOP));

        // Ready load: issue visible two cycles after the insert drive
        bus.LSunwork = 1'b1;
        d = cyc;
        push(32'h100, 32'h0, 32'd4, 4'd3, LW, d + 2);
        ins(LW, 32'h100, C_FREE, 32'h77, C_FREE, 32'd4, 4'd3);
        wait_cyc(4);

        // Pending store resolved by ALU broadcast three edges after insert
        d = cyc;
        push(32'h200, 32'hDEADBEEF, 32'd8, C_FREE, SW, d + 5);
        ins(SW, 32'h200, C_FREE, 32'h0, 4'd5, 32'd8, C_FREE);
        wait_cyc(2);
        bcast_alu(4'd5, 32'hDEADBEEF);
        wait_cyc(4);

        // Same-cycle snoop of the LS broadcast on the insert path
        d = cyc;
        push(32'h55, 32'h0, 32'd0, 4'd6, LB, d + 2);
        bus.LSROBen = 1'b1; bus.LSROBtag = 4'd2; bus.LSROBdata = 32'h55;
        ins(LB, 32'h999, 4'd2, 32'h88, C_FREE, 32'd0, 4'd6);
        bus.LSROBen = 1'b0;
        wait_cyc(4);

        // Ordering: ready store stays behind a blocked load
        ins(LW, 32'hBAD, 4'd7, 32'h0, C_FREE, 32'h10, 4'd1);
        ins(SW, 32'h300, C_FREE, 32'h44, C_FREE, 32'hC, C_FREE);
        wait_cyc(4);
        d = cyc;
        push(32'h400, 32'h0, 32'h10, 4'd1, LW, d + 2);
        push(32'h300, 32'h44, 32'hC, C_FREE, SW, d + 4);
        bcast_alu(4'd7, 32'h400);
        wait_cyc(6);

        // Fill to capacity with LS stalled; a 9th insert is dropped
        bus.LSunwork = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (j == 7) chk("full_at_7", 32'(bus.lsbFull), 32'd0);
            ins(((j % 2) == 1) ? SB : LW, 32'h1000 + 32'(j), C_FREE, 32'h2000 + 32'(j), C_FREE,
                32'(j), ((j % 2) == 1) ? C_FREE : 4'(8 + j));
        end
        chk("full_at_8", 32'(bus.lsbFull), 32'd1);
        ins(LW, 32'hF00D, C_FREE, 32'h0, C_FREE, 32'h0, 4'd2);
        chk("full_after_drop", 32'(bus.lsbFull), 32'd1);
        s = cyc;
        for (int j = 0; j < 8; j++) begin
            push(32'h1000 + 32'(j), ((j % 2) == 1) ? 32'h2000 + 32'(j) : 32'h0, 32'(j),
                 ((j % 2) == 1) ? C_FREE : 4'(8 + j), ((j % 2) == 1) ? SB : LW, s + 1 + 2 * j);
        end
        bus.LSunwork = 1'b1;
        wait_cyc(20);
        chk("drained_full", 32'(bus.lsbFull), 32'd0);
        chk("drained_sb", 32'(sb.size()), 32'd0);

        // Refill across the wrap while issuing
        d = cyc;
        for (int j = 0; j < 8; j++) begin
            push(32'h3000 + 32'(j), ((j % 2) == 0) ? 32'h4000 + 32'(j) : 32'h0, 32'h40 + 32'(j),
                 ((j % 2) == 0) ? C_FREE : 4'(j), ((j % 2) == 0) ? SH : LHU, d + 2 + 2 * j);
        end
        for (int j = 0; j < 8; j++) begin
            ins(((j % 2) == 0) ? SH : LHU, 32'h3000 + 32'(j), C_FREE, 32'h4000 + 32'(j), C_FREE,
                32'h40 + 32'(j), ((j % 2) == 0) ? C_FREE : 4'(j));
        end
        wait_cyc(20);
        chk("refill_sb", 32'(sb.size()), 32'd0);

        // Reset while the issue strobe is high
        bus.LSunwork = 1'b0;
        for (int j = 0; j < 3; j++) begin
            ins(LW, 32'h5000 + 32'(j), C_FREE, 32'h0, C_FREE, 32'h0, 4'(j + 1));
        end
        s = cyc;
        push(32'h5000, 32'h0, 32'h0, 4'd1, LW, s + 1);
        bus.LSunwork = 1'b1;
        wait_cyc(1);
        chk("pre_rst_workEn", 32'(bus.LSworkEn), 32'd1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("post_rst_workEn", 32'(bus.LSworkEn), 32'd0);
        chk("post_rst_count",  32'(dut.r_count), 32'd0);
        chk("post_rst_operandO", bus.operandO, 32'd0);
        chk("post_rst_opCode", 32'(bus.opCode), 32'(NOP));
        wait_cyc(10);
        chk("post_rst_sb", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
